// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: sums the popcount of 16-bit words over a frame
// of up to NUM_WORDS words and presents the total on a registered valid/ready port.

module pc_popcount16 #(
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic [15:0] a,
  output logic [4:0]  count
);

  if (IMPL_TYPE == 0) begin : g_serial
    always_comb begin
      count = '0;
      for (int i = 0; i < 16; i++) begin
        count = count + 5'(a[i]);
      end
    end
  end else begin : g_tree
    // Balanced adder tree: pairs of bits, then pairs of partial sums.
    logic [1:0] lvl1 [8];
    logic [2:0] lvl2 [4];
    logic [3:0] lvl3 [2];

    for (genvar g = 0; g < 8; g++) begin : g_lvl1
      assign lvl1[g] = {1'b0, a[2*g]} + {1'b0, a[2*g+1]};
    end
    for (genvar g = 0; g < 4; g++) begin : g_lvl2
      assign lvl2[g] = {1'b0, lvl1[2*g]} + {1'b0, lvl1[2*g+1]};
    end
    for (genvar g = 0; g < 2; g++) begin : g_lvl3
      assign lvl3[g] = {1'b0, lvl2[2*g]} + {1'b0, lvl2[2*g+1]};
    end
    assign count = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
  end

endmodule

module pc_acc_adder #(
  parameter int unsigned W         = 8,
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  if (IMPL_TYPE == 0) begin : g_behav
    assign sum = a + b;
  end else begin : g_ripple
    // Carry-out is dropped: callers size W so the sum cannot overflow.
    logic carry;
    always_comb begin
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < int'(W); i++) begin
        sum[i] = a[i] ^ b[i] ^ carry;
        carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
    end
  end

endmodule

module popcount_stream_acc #(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned IMPL_TYPE = 0,
  localparam int unsigned CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          A,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] Y,
  output logic [CNT_W-1:0]     out_words
);

  if (NUM_WORDS < 1) begin : g_bad_num_words
    $error("popcount_stream_acc: NUM_WORDS must be at least 1");
  end
  if (ACC_WIDTH < 5 + $clog2(NUM_WORDS)) begin : g_bad_acc_width
    $error("popcount_stream_acc: ACC_WIDTH too small to hold a full frame total");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;

  logic [4:0]           pc;
  logic [ACC_WIDTH-1:0] pc_ext;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0]     cnt_base;
  logic [CNT_W-1:0]     cnt_next;
  logic                 acc_en;
  logic                 frame_end;

  pc_popcount16 #(
    .IMPL_TYPE(IMPL_TYPE)
  ) u_popcount (
    .a    (A),
    .count(pc)
  );

  assign pc_ext = ACC_WIDTH'(pc);

  // A word only extends the running frame in ACCUM; otherwise it starts a new one.
  assign acc_base = (state == S_ACCUM) ? acc : '0;
  assign cnt_base = (state == S_ACCUM) ? cnt : '0;

  pc_acc_adder #(
    .W        (ACC_WIDTH),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_acc_add (
    .a  (acc_base),
    .b  (pc_ext),
    .sum(acc_sum)
  );

  pc_acc_adder #(
    .W        (CNT_W),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_cnt_add (
    .a  (cnt_base),
    .b  (CNT_W'(1)),
    .sum(cnt_next)
  );

  assign in_ready  = !rst && ((state != S_DONE) || out_ready);
  assign acc_en    = in_valid && in_ready;
  assign frame_end = in_last || (cnt_next == CNT_W'(NUM_WORDS));

  // Result release first; an accepted word in the same cycle overrides the idle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      Y         <= '0;
      out_words <= '0;
    end else begin
      if ((state == S_DONE) && out_ready) begin
        state     <= S_IDLE;
        acc       <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
      end
      if (acc_en) begin
        acc <= acc_sum;
        cnt <= cnt_next;
        if (frame_end) begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          Y         <= acc_sum;
          out_words <= cnt_next;
        end else begin
          state <= S_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Scoreboard bench for popcount_stream_acc: stimulus pushes expected frame results,
// a negedge monitor pops and compares them on every output handshake.

module tb_popcount_stream_acc;

  localparam int unsigned NW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = $clog2(NW + 1);

  typedef struct packed {
    logic [AW-1:0] y;
    logic [CW-1:0] n;
  } res_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   A;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] Y;
  logic [CW-1:0] out_words;

  res_t exp_q[$];
  int   checks;
  int   errors;
  int   pushed;
  int   popped;
  bit   use_model;
  bit   rand_rdy;
  int   m_acc;
  int   m_cnt;

  popcount_stream_acc #(
    .NUM_WORDS(NW),
    .ACC_WIDTH(AW),
    .IMPL_TYPE(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .out_words(out_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int y, input int n);
    exp_q.push_back('{y: AW'(y), n: CW'(n)});
    pushed++;
  endtask

  // Advance one cycle; inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one word and hold it until accepted; returns the cycles it took.
  task automatic send_word(input logic [15:0] a, input logic last, output int waited);
    bit got;
    A        = a;
    in_last  = last;
    in_valid = 1'b1;
    got      = 1'b0;
    waited   = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      got = in_ready;
      tick();
      waited++;
    end
    if (!got) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (got && use_model) begin
      m_acc += $countones(a);
      m_cnt++;
      if (last || m_cnt == int'(NW)) begin
        push_exp(m_acc, m_cnt);
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  // Monitor: result compare on handshake, stability compare while stalled.
  initial begin
    res_t held;
    res_t e;
    bit   hold_prev;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (hold_prev && !rst) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_y", int'(Y), int'(held.y));
        check("hold_words", int'(out_words), int'(held.n));
      end
      hold_prev = out_valid && !out_ready && !rst;
      held      = '{y: Y, n: out_words};
      if (out_valid && out_ready && !rst) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("y", int'(Y), int'(e.y));
          check("words", int'(out_words), int'(e.n));
        end
      end
    end
  end

  initial begin
    int        waited;
    int        len;
    int        budget;
    logic      lst;
    checks    = 0;
    errors    = 0;
    pushed    = 0;
    popped    = 0;
    use_model = 1'b0;
    rand_rdy  = 1'b0;
    m_acc     = 0;
    m_cnt     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    A         = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y", int'(Y), 0);
    check("rst_words", int'(out_words), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", int'(in_ready), 1);

    // Eight full words back to back, frame closes on the count.
    push_exp(128, 8);
    for (int i = 0; i < 8; i++) send_word(16'hFFFF, 1'b0, waited);
    check("t1_latency_valid", int'(out_valid), 1);
    tick();
    check("t1_back_to_idle", int'(out_valid), 0);

    // Early close with in_last.
    push_exp(10, 4);
    send_word(16'h0001, 1'b0, waited);
    send_word(16'h8000, 1'b0, waited);
    send_word(16'h00FF, 1'b0, waited);
    send_word(16'h0000, 1'b1, waited);
    tick();

    // Backpressure, then simultaneous result and input handshakes.
    out_ready = 1'b0;
    push_exp(5, 2);
    send_word(16'h0003, 1'b0, waited);
    send_word(16'h0007, 1'b1, waited);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_in_ready_low", int'(in_ready), 0);
      check("t3_out_valid", int'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    push_exp(8, 8);
    send_word(16'h0F0F, 1'b0, waited);
    check("t3_no_bubble", waited, 1);
    for (int i = 0; i < 7; i++) send_word(16'h0000, 1'b0, waited);
    tick();

    // Asynchronous reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) send_word(16'h1111, 1'b0, waited);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t4_rst_out_valid", int'(out_valid), 0);
    check("t4_rst_y", int'(Y), 0);
    check("t4_rst_words", int'(out_words), 0);
    check("t4_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(64, 8);
    for (int i = 0; i < 8; i++) send_word(16'hAAAA, 1'b0, waited);
    tick();

    // Single-word frame.
    push_exp(15, 1);
    send_word(16'h7FFF, 1'b1, waited);
    check("t5_latency_valid", int'(out_valid), 1);
    tick();

    // Random traffic checked against the reference model.
    use_model = 1'b1;
    rand_rdy  = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 10);
      for (int w = 0; w < len && w < int'(NW); w++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        lst = (w == len - 1);
        send_word(16'($urandom()), lst, waited);
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    tick();
    check("queue_drained", exp_q.size(), 0);
    check("result_count", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_stream_acc.md
Name: popcount_stream_acc

Overview:
Streaming popcount accumulator that sits directly downstream of the 16-bit combinational popcount stage. It accepts a stream of 16-bit words over a valid/ready handshake and computes each word's popcount combinationally (instantiating the existing 16-bit popcount block with IMPL_TYPE passed through). It sums the popcounts across a frame of up to NUM_WORDS words and presents the frame total on a registered valid/ready output. It is used by PIM benchmark harnesses that need bit-density totals over multi-word vectors.

Parameters:
NUM_WORDS, 8, maximum words per frame; must be ≥1.
ACC_WIDTH, 8, width of Y; must be ≥ 5 + clog2(NUM_WORDS), otherwise elaboration fails.
IMPL_TYPE, 0, implementation selector forwarded unchanged to the popcount and adder sub-blocks.
CNT_W, clog2(NUM_WORDS+1), derived localparam; width of out_words.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  A is valid this cycle.
in_ready  output  1  block can accept A this cycle.
A  input  16  data word.
in_last  input  1  accepted word closes the frame early; ignored unless in_valid && in_ready.
out_valid  output  1  Y/out_words hold a completed frame result.
out_ready  input  1  consumer accepts the result.
Y  output  ACC_WIDTH  frame popcount total.
out_words  output  CNT_W  number of words in the frame.

Behaviour:
- Reset is asynchronous, active-high: one clock; reset is asynchronous and active-high.
- While rst is high: state=IDLE, acc=0, cnt=0, out_valid=0, Y=0, out_words=0, in_ready=0. Any partial frame is discarded, with no output.
- Accept condition: acc_en = in_valid && in_ready.
- in_ready = !rst && (state != DONE || out_ready). This is combinational from out_ready.
- pc = popcount(A), 5 bits (0..16), zero-extended to ACC_WIDTH. Additions never overflow given the ACC_WIDTH rule; there is no saturation logic.
- Frame ends on the accepted word when in_last=1 or when that word is word number NUM_WORDS.
- FSM:
  - IDLE: on acc_en, load acc=pc and cnt=1. Go to DONE if the frame ends, else go to ACCUM.
  - ACCUM: on acc_en, set acc=acc+pc and cnt=cnt+1. Go to DONE if the frame ends, else stay in ACCUM. With no acc_en, hold.
  - DONE: out_valid=1, Y=acc, out_words=cnt.
    - out_ready=1 with no acc_en: go to IDLE and clear acc/cnt.
    - out_ready=1 with acc_en (simultaneous handshakes): complete the output and start a new frame in the same cycle, exactly as in IDLE's acc_en branch. No bubble is inserted.
    - out_ready=0: hold everything. Y and out_words must stay stable, and in_ready=0.
- Latency: out_valid rises the cycle after the frame-ending word is accepted. Throughput is 1 word/cycle, including across frame boundaries when out_ready=1.
- Y and out_words are driven from registers. There is no combinational path from A to Y.
- The in_valid gaps in ACCUM are unbounded; the frame waits indefinitely.
- When NUM_WORDS=1, every accepted word goes IDLE→DONE.
- The cnt register never exceeds NUM_WORDS. in_last on word NUM_WORDS is redundant and harmless.
- Outputs are unchanged when out_ready toggles while out_valid=0.

Test Plan:
1. Reset, then 8 back-to-back words 0xFFFF with out_ready=1 → out_valid high 1 cycle after the 8th accept, Y=128, out_words=8; then IDLE.
2. Words 0x0001, 0x8000, 0x00FF, 0x0000 with in_last on the 4th → Y=10, out_words=4.
3. Backpressure: a frame completes with out_ready=0 for 5 cycles → in_ready=0, and Y/out_words are stable for all 5 cycles. Then out_ready=1 in the same cycle as in_valid with A=0x0F0F → the result handshakes and the word is accepted. The next frame's acc=8, and 7 further words of 0x0000 → Y=8, out_words=8.
4. Assert rst asynchronously mid-frame after 3 words → out_valid=0, Y=0, in_ready=0 immediately. After release, 8×0xAAAA → Y=64, and no residue from the aborted frame.
5. in_last on the first word 0x7FFF → out_valid the next cycle, Y=15, out_words=1.
6. Random words, random in_valid gaps, random out_ready, random in_last, 1000 frames → all results match the reference model. Also check that no words are lost or duplicated, and that Y is stable while out_valid && !out_ready.
